// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared fetch definitions: FSM states, word widths and the PC window mask.
package inst_fetch_ctrl_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_e;

    // Clears the bits above the ROM window and the byte offset within a word.
    function automatic logic [PC_W-1:0] pc_mask(input logic [PC_W-1:0] pc_in,
                                                input int addr_w);
        logic [PC_W-1:0] win;
        win = (PC_W'(1) << (addr_w + 2)) - PC_W'(1);
        return pc_in & win & ~PC_W'(3);
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// ROM read port plus decode-side valid/ready channel of the fetch controller.
interface inst_fetch_ctrl_if #(
    parameter int ADDR_W = 6
);
    import inst_fetch_ctrl_pkg::*;

    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [INST_W-1:0] rom_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_code;
    logic [PC_W-1:0]   inst_pc;

    modport master (
        output rom_en, rom_addr, inst_valid, inst_code, inst_pc,
        input  rom_data, inst_ready
    );

    modport slave (
        input  rom_en, rom_addr, inst_valid, inst_code, inst_pc,
        output rom_data, inst_ready
    );

endinterface

// File: rtl/inst_fetch_ctrl_pc_reg.sv
// Fetch PC register: masked reset value, redirect load and wrapping +4 increment.
// Latency: new value visible the cycle after load/inc.
// Backpressure: none; the caller decides when to increment.
module fetch_pc_reg
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int              ADDR_W   = 6,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc_i,
    input  logic            load_i,
    input  logic [PC_W-1:0] load_pc_i,
    output logic [PC_W-1:0] pc_o
);

    localparam logic [PC_W-1:0] RESET_PC_M = pc_mask(RESET_PC, ADDR_W);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // A redirect overrides the increment of a completing read.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = pc_mask(load_pc_i, ADDR_W);
        end else if (inc_i) begin
            pc_d = pc_mask(pc_q + PC_W'(4), ADDR_W);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC_M;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer between a 1-cycle synchronous ROM and decode.
// Latency: first inst_valid 2 cycles after issue; 1 instruction per 2 cycles steady state.
// Backpressure: holds inst_* stable and issues nothing until inst_ready; halt gates new issue.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int              ADDR_W   = 6,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic [PC_W-1:0]   pc,
    inst_fetch_ctrl_if.master bus
);

    fetch_state_e      state_q;
    logic              inst_valid_q;
    logic [INST_W-1:0] inst_code_q;
    logic [PC_W-1:0]   inst_pc_q;

    logic            hs;
    logic            issue;
    logic            pc_inc;
    logic [PC_W-1:0] pc_cur;

    assign hs = inst_valid_q & bus.inst_ready;

    // Redirect and reset suppress issue so no stale read is ever launched.
    always_comb begin
        issue = 1'b0;
        if (!rst && !redirect && !halt) begin
            issue = (state_q == S_ISSUE) || ((state_q == S_HOLD) && hs);
        end
    end

    assign pc_inc = !rst && !redirect && (state_q == S_WAIT);

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (pc_inc),
        .load_i    (redirect),
        .load_pc_i (redirect_pc),
        .pc_o      (pc_cur)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_ISSUE;
            inst_valid_q <= 1'b0;
            inst_code_q  <= '0;
            inst_pc_q    <= '0;
        end else if (redirect) begin
            state_q      <= S_ISSUE;
            inst_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_ISSUE: begin
                    if (!halt) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    inst_code_q  <= bus.rom_data;
                    inst_pc_q    <= pc_cur;
                    inst_valid_q <= 1'b1;
                    state_q      <= S_HOLD;
                end
                S_HOLD: begin
                    if (hs) begin
                        inst_valid_q <= 1'b0;
                        state_q      <= halt ? S_ISSUE : S_WAIT;
                    end
                end
                default: begin
                    state_q      <= S_ISSUE;
                    inst_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rom_en     = issue;
    assign bus.rom_addr   = pc_cur[ADDR_W+1:2];
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst_code  = inst_code_q;
    assign bus.inst_pc    = inst_pc_q;
    assign pc             = pc_cur;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed scenarios plus random traffic against a fetch-order model.
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_w;

    inst_fetch_ctrl_if #(.ADDR_W(6)) f ();

    inst_fetch_ctrl #(.ADDR_W(6), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .halt        (halt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc_w),
        .bus         (f)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [64];
    always @(posedge clk) if (f.rom_en) f.rom_data <= rom[f.rom_addr];

    int n_chk  = 0;
    int n_fail = 0;

    // Model: address of the next instruction decode should receive, plus read-in-flight timer.
    logic [31:0] exp_pc;
    int          pend;
    logic        prev_valid, prev_stall, was_rst;
    logic [31:0] prev_code, prev_ipc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        logic        hs, exp_en;
        logic [31:0] nxt;
        @(negedge clk);
        if (was_rst) begin
            chk("rst_valid", f.inst_valid, 0);
            chk("rst_code", f.inst_code, 0);
            chk("rst_ipc", f.inst_pc, 0);
        end
        if (pend != 0) begin
            pend--;
            chk(pend == 0 ? "latency_valid" : "wait_no_valid", f.inst_valid, (pend == 0));
        end else if (!prev_valid) begin
            chk("no_spurious_valid", f.inst_valid, 0);
        end
        if (prev_stall) begin
            chk("stall_valid", f.inst_valid, 1);
            chk("stall_code", f.inst_code, prev_code);
            chk("stall_ipc", f.inst_pc, prev_ipc);
        end
        if (f.inst_valid) begin
            chk("inst_pc", f.inst_pc, exp_pc);
            chk("inst_code", f.inst_code, rom[exp_pc[7:2]]);
        end
        hs     = f.inst_valid && f.inst_ready && !redirect && !rst;
        exp_en = !rst && !redirect && !halt && (pend == 0) && (!f.inst_valid || f.inst_ready);
        nxt    = hs ? ((exp_pc + 32'd4) & 32'hFC) : exp_pc;
        chk("rom_en", f.rom_en, exp_en);
        if (f.rom_en) chk("rom_addr", f.rom_addr, nxt >> 2);
        if (pend == 0 && !f.inst_valid) chk("pc_idle", pc_w, exp_pc);
        chk("pc_window", pc_w & ~32'hFC, 0);

        prev_valid = f.inst_valid;
        prev_stall = f.inst_valid && !f.inst_ready && !redirect && !rst;
        prev_code  = f.inst_code;
        prev_ipc   = f.inst_pc;
        if (rst) begin
            exp_pc  = 32'h0;
            pend    = 0;
            was_rst = 1'b1;
        end else begin
            was_rst = 1'b0;
            if (redirect) begin
                exp_pc = redirect_pc & 32'hFC;
                pend   = 0;
            end else begin
                if (hs) exp_pc = nxt;
                if (f.rom_en) pend = 2;
            end
        end
    endtask

    task automatic wait_valid(input string tag);
        logic got;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            sample();
            if (f.inst_valid) got = 1'b1;
            else tick();
        end
        chk(tag, got, 1);
    endtask

    initial begin
        logic        seen, done, got;
        logic [31:0] h_pc;
        rst = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = '0; f.inst_ready = 1'b0;
        for (int i = 0; i < 64; i++) rom[i] = 32'(i);
        exp_pc = 0; pend = 0; prev_valid = 0; prev_stall = 0; was_rst = 0;
        prev_code = 0; prev_ipc = 0;

        // Reset state
        tick();
        sample();
        chk("reset_pc", pc_w, 32'h0);
        chk("reset_valid", f.inst_valid, 0);
        chk("reset_code", f.inst_code, 0);
        chk("reset_ipc", f.inst_pc, 0);
        tick();

        // 1: sequential fetch with ready held high
        rst = 1'b0; f.inst_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sample();
            chk("t1_rom_en", f.rom_en, (k % 2 == 0));
            chk("t1_valid", f.inst_valid, (k >= 2 && k % 2 == 0));
            if (k % 2 == 0) chk("t1_addr", f.rom_addr, 32'(k / 2));
            if (k >= 2 && k % 2 == 0) chk("t1_ipc", f.inst_pc, 32'((k / 2 - 1) * 4));
            tick();
        end

        // 2: decode stalls for 5 cycles on the instruction at 0x0C
        f.inst_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sample();
            chk("t2_code", f.inst_code, 32'd3);
            chk("t2_ipc", f.inst_pc, 32'hC);
            chk("t2_rom_en", f.rom_en, 0);
            tick();
        end
        f.inst_ready = 1'b1;
        sample();
        chk("t2_resume_en", f.rom_en, 1);
        chk("t2_resume_addr", f.rom_addr, 32'd4);
        tick();

        // 3: run through the top of the window with random ready
        seen = 1'b0; done = 1'b0;
        for (int n = 0; n < 800 && !done; n++) begin
            f.inst_ready = ($urandom_range(0, 3) != 0);
            sample();
            if (seen && f.inst_valid) begin
                chk("t3_wrap_ipc", f.inst_pc, 32'h0);
                done = 1'b1;
            end else if (f.inst_valid && f.inst_ready && f.inst_pc == 32'hFC) begin
                seen = 1'b1;
                chk("t3_wrap_addr", f.rom_addr, 0);
            end
            tick();
        end
        chk("t3_reached", done, 1);

        // 4: redirect while a read is in flight
        f.inst_ready = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            sample();
            got = f.rom_en;
            tick();
        end
        chk("t4_issued", got, 1);
        redirect = 1'b1; redirect_pc = 32'h0000_1237;
        sample();
        chk("t4_rom_en_off", f.rom_en, 0);
        tick();
        redirect = 1'b0;
        sample();
        chk("t4_dropped", f.inst_valid, 0);
        chk("t4_pc", pc_w, 32'h34);
        chk("t4_rom_en", f.rom_en, 1);
        chk("t4_addr", f.rom_addr, 32'h0D);
        tick();
        sample();
        tick();
        sample();
        chk("t4_valid", f.inst_valid, 1);
        chk("t4_ipc", f.inst_pc, 32'h34);
        tick();

        // 5: halt raised while an instruction is held
        f.inst_ready = 1'b0;
        wait_valid("t5_hold");
        tick();
        halt = 1'b1; f.inst_ready = 1'b1;
        h_pc = exp_pc;
        sample();
        chk("t5_no_issue", f.rom_en, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("t5_halted_en", f.rom_en, 0);
            chk("t5_halted_valid", f.inst_valid, 0);
            tick();
        end
        halt = 1'b0;
        sample();
        chk("t5_resume_en", f.rom_en, 1);
        chk("t5_resume_pc", pc_w, (h_pc + 32'd4) & 32'hFC);
        tick();

        // 6: reset and redirect together while holding
        f.inst_ready = 1'b0;
        wait_valid("t6_hold");
        tick();
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
        sample();
        chk("t6_rom_en", f.rom_en, 0);
        tick();
        rst = 1'b0; redirect = 1'b0;
        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        sample();
        chk("t6_pc", pc_w, 32'h0);
        chk("t6_valid", f.inst_valid, 0);
        chk("t6_code", f.inst_code, 0);
        tick();

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            f.inst_ready = ($urandom_range(0, 3) != 0);
            halt         = ($urandom_range(0, 7) == 0);
            redirect     = ($urandom_range(0, 15) == 0);
            redirect_pc  = $urandom;
            rst          = ($urandom_range(0, 199) == 0);
            sample();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
